// File: rtl/mem_stage_lsu.sv
// Memory-access pipeline stage: one load/store per instruction over a single-outstanding
// req/rsp port, forwarding the writeback payload. Define LSU_PERF_CNT_EN for perf counters.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [148:0] in_bits,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [107:0] out_bits,
    output logic [31:0]  mem_pc,
    output logic         req_valid,
    input  logic         req_ready,
    output logic [31:0]  req_addr,
    output logic         req_we,
    output logic [31:0]  req_wdata,
    output logic [3:0]   req_wstrb,
    input  logic         rsp_valid,
    input  logic [31:0]  rsp_rdata,
    input  logic         rsp_err
`ifdef LSU_PERF_CNT_EN
    ,
    output logic [31:0]  perf_ld_cnt,
    output logic [31:0]  perf_st_cnt,
    output logic [31:0]  perf_wait_cnt
`endif
);

    localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

    // Everything but MemRe must survive past accept.
    typedef struct packed {
        logic [31:0] pc;
        logic        fence_i;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [2:0]  mem_width;
        logic [2:0]  mem_sext;
        logic        mem_we;
        logic [31:0] csrs_out;
        logic [1:0]  mem_to_reg;
        logic [2:0]  csrs_addr;
        logic [4:0]  rd;
        logic        csrs_we;
        logic        reg_we;
    } hold_t;

    typedef struct packed {
        logic  mem_re;
        hold_t h;
    } in_t;

    typedef struct packed {
        logic        fault;
        logic [31:0] pc;
        logic        fence_i;
        logic [31:0] wb_data;
        logic [31:0] csrs_out;
        logic [2:0]  csrs_addr;
        logic [4:0]  rd;
        logic        csrs_we;
        logic        reg_we;
    } out_t;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, DONE} state_t;

    function automatic logic misaligned(hold_t h);
        case (h.mem_width)
            3'b000:  misaligned = 1'b0;
            3'b001:  misaligned = h.alu_result[0];
            default: misaligned = |h.alu_result[1:0];
        endcase
    endfunction

    function automatic logic [3:0] strb_of(hold_t h);
        logic [3:0] base;
        case (h.mem_width)
            3'b000:  base = 4'b0001;
            3'b001:  base = 4'b0011;
            default: base = 4'b1111;
        endcase
        return base << h.alu_result[1:0];
    endfunction

    function automatic out_t build(hold_t h, logic fault, logic [31:0] rdata);
        out_t        o;
        logic [31:0] sh;
        logic [31:0] ld;
        logic        sx;
        sh = rdata >> {h.alu_result[1:0], 3'b000};
        sx = (h.mem_sext == 3'b001);
        case (h.mem_width)
            3'b000:  ld = {{24{sx & sh[7]}}, sh[7:0]};
            3'b001:  ld = {{16{sx & sh[15]}}, sh[15:0]};
            default: ld = sh;
        endcase
        o.fault     = fault;
        o.pc        = h.pc;
        o.fence_i   = h.fence_i;
        o.csrs_out  = h.csrs_out;
        o.csrs_addr = h.csrs_addr;
        o.rd        = h.rd;
        o.csrs_we   = h.csrs_we & ~fault;
        o.reg_we    = h.reg_we & ~fault;
        case (h.mem_to_reg)
            2'b01:   o.wb_data = ld;
            2'b10:   o.wb_data = h.csrs_out;
            default: o.wb_data = h.alu_result;
        endcase
        if (fault) o.wb_data = '0;
        return o;
    endfunction

    state_t        state;
    hold_t         held;
    out_t          out_q;
    logic [CW-1:0] tmo_cnt;
    in_t           in_w;
    logic          in_mem;
    logic          in_mis;
    logic          accept;

    assign in_w     = in_t'(in_bits);
    assign in_mem   = in_w.mem_re | in_w.h.mem_we;
    assign in_mis   = in_mem & misaligned(in_w.h);
    assign in_ready = (state == IDLE) | ((state == DONE) & out_ready);
    assign accept   = in_valid & in_ready;

    assign out_valid = (state == DONE);
    assign out_bits  = out_q;

    // Request fields come straight from the held payload, so they stay stable until req_ready.
    assign req_valid = (state == REQ);
    assign req_addr  = {held.alu_result[31:2], 2'b00};
    assign req_we    = req_valid & held.mem_we;
    assign req_wdata = held.rs2_data << {held.alu_result[1:0], 3'b000};
    assign req_wstrb = req_valid ? strb_of(held) : 4'b0000;

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= IDLE;
            held    <= '0;
            out_q   <= '0;
            tmo_cnt <= '0;
            mem_pc  <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        held   <= in_w.h;
                        mem_pc <= in_w.h.pc;
                        if (in_mem && !in_mis) begin
                            state <= REQ;
                        end else begin
                            state <= DONE;
                            out_q <= build(in_w.h, in_mis, 32'd0);
                        end
                    end else if (state == DONE && out_ready) begin
                        state  <= IDLE;
                        mem_pc <= '0;
                    end
                end
                REQ: begin
                    if (req_ready) begin
                        state   <= WAIT_RSP;
                        tmo_cnt <= '0;
                    end
                end
                WAIT_RSP: begin
                    if (rsp_valid) begin
                        out_q <= build(held, rsp_err, rsp_rdata);
                        state <= DONE;
                    end else if (tmo_cnt == CW'(TIMEOUT_CYC)) begin
                        out_q <= build(held, 1'b1, 32'd0);
                        state <= DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef LSU_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_ld_cnt   <= '0;
            perf_st_cnt   <= '0;
            perf_wait_cnt <= '0;
        end else begin
            if (state == WAIT_RSP && rsp_valid) begin
                if (held.mem_we) perf_st_cnt <= perf_st_cnt + 32'd1;
                else             perf_ld_cnt <= perf_ld_cnt + 32'd1;
            end
            if (state == REQ || state == WAIT_RSP) perf_wait_cnt <= perf_wait_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed + randomized bench for mem_stage_lsu against a field-level reference model.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    typedef struct packed {
        logic        mem_re;
        logic [31:0] pc;
        logic        fence_i;
        logic [31:0] alu_result;
        logic [31:0] rs2_data;
        logic [2:0]  mem_width;
        logic [2:0]  mem_sext;
        logic        mem_we;
        logic [31:0] csrs_out;
        logic [1:0]  mem_to_reg;
        logic [2:0]  csrs_addr;
        logic [4:0]  rd;
        logic        csrs_we;
        logic        reg_we;
    } txn_t;

    logic         clock = 0;
    logic         reset;
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [148:0] in_bits;
    logic [107:0] out_bits;
    logic [31:0]  mem_pc, req_addr, req_wdata, rsp_rdata;
    logic         req_valid, req_ready, req_we, rsp_valid, rsp_err;
    logic [3:0]   req_wstrb;

    int errors = 0;
    int checks = 0;

    logic [107:0] last_out;
    logic [31:0]  last_addr, last_wdata;
    logic         last_we;
    logic [3:0]   last_wstrb;

    always #5 clock = ~clock;

    mem_stage_lsu #(.TIMEOUT_CYC(TO)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_bits(in_bits),
        .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits),
        .mem_pc(mem_pc),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_we(req_we), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    task automatic chk(input string tag, input logic [107:0] obs, input logic [107:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_mem(txn_t t);
        return t.mem_re || t.mem_we;
    endfunction

    function automatic bit is_misaligned(txn_t t);
        int off = int'(t.alu_result % 4);
        if (!is_mem(t) || t.mem_width == 0) return 0;
        if (t.mem_width == 1) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [107:0] model_out(txn_t t, bit fault, logic [31:0] rdata);
        int          off = int'(t.alu_result % 4);
        logic [31:0] word, ld, wb;
        word = rdata >> (8 * off);
        if (t.mem_width == 0) begin
            ld = word % 256;
            if (t.mem_sext == 1 && ld >= 128) ld = ld + 32'hFFFFFF00;
        end else if (t.mem_width == 1) begin
            ld = word % 65536;
            if (t.mem_sext == 1 && ld >= 32768) ld = ld + 32'hFFFF0000;
        end else begin
            ld = word;
        end
        case (t.mem_to_reg)
            2'd1:    wb = ld;
            2'd2:    wb = t.csrs_out;
            default: wb = t.alu_result;
        endcase
        if (fault) wb = 0;
        return {fault, t.pc, t.fence_i, wb, t.csrs_out, t.csrs_addr, t.rd,
                t.csrs_we & !fault, t.reg_we & !fault};
    endfunction

    function automatic logic [31:0] model_wdata(txn_t t);
        return t.rs2_data << (8 * int'(t.alu_result % 4));
    endfunction

    function automatic logic [3:0] model_wstrb(txn_t t);
        int s = (t.mem_width == 0) ? 1 : (t.mem_width == 1) ? 3 : 15;
        s = (s << int'(t.alu_result % 4)) % 16;
        return 4'(s);
    endfunction

    // One instruction from accept to WB handoff; all driving/sampling on falling edges.
    task automatic run_txn(input txn_t t, input int rdy_d, input int rsp_d, input bit err,
                           input bit never, input logic [31:0] rdata, input int ord_d);
        logic [107:0] e;
        int           k;
        bit           mis = is_misaligned(t);
        chk("in_ready_idle", in_ready, 1);
        in_valid = 1;
        in_bits  = t;
        @(negedge clock);
        in_valid = 0;
        chk("mem_pc_held", mem_pc, t.pc);
        if (is_mem(t) && !mis) begin
            last_addr  = req_addr;
            last_we    = req_we;
            last_wdata = req_wdata;
            last_wstrb = req_wstrb;
            for (int i = 0; i <= rdy_d; i++) begin
                chk("req_valid", req_valid, 1);
                chk("req_addr", req_addr, {t.alu_result[31:2], 2'b00});
                chk("req_we", req_we, t.mem_we);
                if (t.mem_we) chk("req_wdata", req_wdata, model_wdata(t));
                chk("req_wstrb", req_wstrb, model_wstrb(t));
                chk("no_out_in_req", out_valid, 0);
                if (i == rdy_d) req_ready = 1;
                @(negedge clock);
            end
            req_ready = 0;
            chk("req_dropped", req_valid, 0);
            if (never) begin
                k = 0;
                while (!out_valid && k < 20) begin
                    @(negedge clock);
                    k++;
                end
                chk("timeout_wait", (k >= TO && k <= TO + 1), 1);
                e = model_out(t, 1, 0);
            end else begin
                repeat (rsp_d) begin
                    chk("no_out_wait", out_valid, 0);
                    @(negedge clock);
                end
                rsp_valid = 1;
                rsp_rdata = rdata;
                rsp_err   = err;
                @(negedge clock);
                rsp_valid = 0;
                rsp_err   = 0;
                e = model_out(t, err, rdata);
            end
        end else begin
            chk("no_req", req_valid, 0);
            e = model_out(t, mis, 0);
        end
        chk("out_valid", out_valid, 1);
        chk("out_bits", out_bits, e);
        chk("mem_pc_done", mem_pc, t.pc);
        // Stray responses while stalled in DONE must not disturb the payload.
        repeat (ord_d) begin
            rsp_valid = 1;
            rsp_rdata = $urandom;
            rsp_err   = 1;
            @(negedge clock);
            rsp_valid = 0;
            rsp_err   = 0;
            chk("out_stable", out_bits, e);
            chk("in_ready_stall", in_ready, 0);
        end
        last_out  = out_bits;
        out_ready = 1;
        @(negedge clock);
        out_ready = 0;
        chk("out_drop", out_valid, 0);
        chk("mem_pc_empty", mem_pc, 0);
    endtask

    initial begin
        txn_t t, t2;
        int   v;
        reset = 1; in_valid = 0; in_bits = '0; out_ready = 0;
        req_ready = 0; rsp_valid = 0; rsp_rdata = '0; rsp_err = 0;
        repeat (2) @(negedge clock);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_req_valid", req_valid, 0);
        chk("rst_req_we", req_we, 0);
        chk("rst_req_wstrb", req_wstrb, 0);
        chk("rst_mem_pc", mem_pc, 0);
        chk("rst_out_bits", out_bits, 0);
        chk("rst_in_ready", in_ready, 1);
        reset = 0;
        @(negedge clock);

        t = '0; t.pc = 32'h100; t.reg_we = 1; t.rd = 5; t.alu_result = 32'h1234;
        run_txn(t, 0, 0, 0, 0, 0, 0);
        chk("alu_wb", last_out[73:42], 32'h1234);

        t = '0; t.pc = 32'h104; t.mem_re = 1; t.mem_width = 0; t.mem_sext = 1;
        t.alu_result = 32'h80000003; t.mem_to_reg = 1; t.reg_we = 1; t.rd = 7;
        run_txn(t, 0, 1, 0, 0, 32'h80FFFFFF, 0);
        chk("lb_addr", last_addr, 32'h80000000);
        chk("lb_we", last_we, 0);
        chk("lb_sext", last_out[73:42], 32'hFFFFFF80);
        t.mem_sext = 0;
        run_txn(t, 1, 0, 0, 0, 32'h80FFFFFF, 0);
        chk("lb_zext", last_out[73:42], 32'h00000080);

        t = '0; t.pc = 32'h108; t.mem_we = 1; t.mem_width = 1;
        t.alu_result = 32'h80000002; t.rs2_data = 32'hABCD;
        run_txn(t, 0, 0, 0, 0, 32'h0, 1);
        chk("sh_wdata", last_wdata, 32'hABCD0000);
        chk("sh_wstrb", last_wstrb, 4'b1100);
        chk("sh_we", last_we, 1);
        chk("sh_regwe", last_out[0], 0);
        chk("sh_fault", last_out[107], 0);

        t = '0; t.pc = 32'h10C; t.mem_re = 1; t.mem_width = 2; t.alu_result = 32'h80000001;
        t.mem_to_reg = 1; t.reg_we = 1; t.csrs_we = 1;
        run_txn(t, 0, 0, 0, 0, 0, 0);
        chk("lw_mis_fault", last_out[107], 1);
        chk("lw_mis_regwe", last_out[0], 0);
        t.alu_result = 32'h80000004;
        run_txn(t, 0, 0, 1, 0, 32'h12345678, 0);
        chk("lw_err_fault", last_out[107], 1);

        t.pc = 32'h110;
        run_txn(t, 3, 0, 0, 1, 0, 2);
        chk("tmo_fault", last_out[107], 1);
        rsp_valid = 1; rsp_rdata = 32'hDEAD; @(negedge clock); rsp_valid = 0;
        chk("late_rsp_out", out_valid, 0);
        chk("late_rsp_req", req_valid, 0);
        chk("late_rsp_rdy", in_ready, 1);

        // Back-to-back ALU ops: second accepted on the first's handoff cycle.
        t = '0; t.pc = 32'h200; t.reg_we = 1; t.rd = 1; t.alu_result = 32'hAAAA;
        t2 = '0; t2.pc = 32'h204; t2.reg_we = 1; t2.rd = 2; t2.alu_result = 32'hBBBB;
        in_valid = 1; in_bits = t;
        @(negedge clock);
        in_bits = t2;
        chk("b2b_a_valid", out_valid, 1);
        chk("b2b_a_bits", out_bits, model_out(t, 0, 0));
        chk("b2b_a_rdy", in_ready, 0);
        chk("b2b_a_pc", mem_pc, 32'h200);
        @(negedge clock);
        chk("b2b_a_stable", out_bits, model_out(t, 0, 0));
        chk("b2b_a_rdy2", in_ready, 0);
        out_ready = 1;
        #1;
        chk("b2b_rdy_pass", in_ready, 1);
        @(negedge clock);
        in_valid = 0;
        chk("b2b_b_valid", out_valid, 1);
        chk("b2b_b_bits", out_bits, model_out(t2, 0, 0));
        chk("b2b_b_pc", mem_pc, 32'h204);
        @(negedge clock);
        out_ready = 0;
        chk("b2b_empty", out_valid, 0);
        chk("b2b_pc0", mem_pc, 0);

        // Reset mid-transaction drops the pending request.
        t = '0; t.pc = 32'h300; t.mem_re = 1; t.mem_width = 2; t.alu_result = 32'h40;
        in_valid = 1; in_bits = t;
        @(negedge clock);
        in_valid = 0;
        chk("mid_req", req_valid, 1);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("mid_rst_req", req_valid, 0);
        chk("mid_rst_pc", mem_pc, 0);
        chk("mid_rst_rdy", in_ready, 1);
        req_ready = 1; @(negedge clock); req_ready = 0;
        chk("mid_no_retry", req_valid, 0);
        chk("mid_no_out", out_valid, 0);

        for (int n = 0; n < 40; n++) begin
            t = txn_t'({$urandom, $urandom, $urandom, $urandom, $urandom});
            v = $urandom_range(0, 2);
            t.mem_re = (v == 1);
            t.mem_we = (v == 2);
            t.mem_width = 3'($urandom_range(0, 4));
            t.mem_sext  = 3'($urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) t.alu_result[1:0] = 2'b00;
            if (v == 1) t.mem_to_reg = 2'($urandom_range(0, 3));
            else begin
                v = $urandom_range(0, 2);
                t.mem_to_reg = (v == 1) ? 2'd3 : 2'(v);
            end
            run_txn(t, $urandom_range(0, 2), $urandom_range(0, 2), ($urandom_range(0, 7) == 0),
                    0, $urandom, $urandom_range(0, 2));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
